// File: rtl/local_mem_avalon_arbiter_pkg.sv
// Shared types and helpers for the local-memory Avalon-MM arbiter.
//   t_arb_state      : arbiter FSM states (ARB, WR_BURST)
//   t_rd_track_entry : one outstanding read command {src_id, burstcount}
//   rr_pick()        : round-robin scan of a request vector from a pointer
// Field widths are sized for the largest supported configuration
// (8 sources, Avalon burstcount up to 11 bits); narrower configs zero-extend.
package local_mem_arb_pkg;

  localparam int MAX_SRC    = 8;
  localparam int SRC_ID_W   = 3;
  localparam int TRK_BCNT_W = 11;

  typedef enum logic [0:0] {
    ARB      = 1'b0,
    WR_BURST = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic [SRC_ID_W-1:0]   src_id;
    logic [TRK_BCNT_W-1:0] burstcount;
  } t_rd_track_entry;

  typedef struct packed {
    logic                vld;
    logic [SRC_ID_W-1:0] idx;
  } t_rr_pick;

  // First set bit of req at or above ptr, wrapping at num_src.
  function automatic t_rr_pick rr_pick(input logic [MAX_SRC-1:0] req,
                                       input logic [SRC_ID_W-1:0] ptr,
                                       input int                  num_src);
    t_rr_pick r;
    int       c;
    r = '0;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < num_src && !r.vld) begin
        c = int'(ptr) + k;
        if (c >= num_src) c = c - num_src;
        if (req[c]) begin
          r.vld = 1'b1;
          r.idx = SRC_ID_W'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/local_mem_avalon_arbiter_if.sv
// Bus bundle between NUM_SRC traffic engines, the arbiter and one
// local-memory bank port.
//   src_* : per-source Avalon-MM masters, concatenated (source 0 in the LSBs)
//   snk_* : single Avalon-MM sink toward memory
// Modports: slave = the arbiter's view; master = engines plus memory (bench).
interface local_mem_avalon_arbiter_if #(
  parameter int NUM_SRC         = 4,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
);
  logic [NUM_SRC-1:0]                 src_read;
  logic [NUM_SRC-1:0]                 src_write;
  logic [NUM_SRC*ADDR_WIDTH-1:0]      src_address;
  logic [NUM_SRC*BURST_CNT_WIDTH-1:0] src_burstcount;
  logic [NUM_SRC*DATA_WIDTH-1:0]      src_writedata;
  logic [NUM_SRC*DATA_WIDTH/8-1:0]    src_byteenable;
  logic [NUM_SRC-1:0]                 src_waitrequest;
  logic [NUM_SRC-1:0]                 src_readdatavalid;
  logic [DATA_WIDTH-1:0]              src_readdata;

  logic                               snk_read;
  logic                               snk_write;
  logic [ADDR_WIDTH-1:0]              snk_address;
  logic [BURST_CNT_WIDTH-1:0]         snk_burstcount;
  logic [DATA_WIDTH-1:0]              snk_writedata;
  logic [DATA_WIDTH/8-1:0]            snk_byteenable;
  logic                               snk_waitrequest;
  logic                               snk_readdatavalid;
  logic [DATA_WIDTH-1:0]              snk_readdata;

  modport slave (
    input  src_read, src_write, src_address, src_burstcount,
           src_writedata, src_byteenable,
    output src_waitrequest, src_readdatavalid, src_readdata,
    output snk_read, snk_write, snk_address, snk_burstcount,
           snk_writedata, snk_byteenable,
    input  snk_waitrequest, snk_readdatavalid, snk_readdata
  );

  modport master (
    output src_read, src_write, src_address, src_burstcount,
           src_writedata, src_byteenable,
    input  src_waitrequest, src_readdatavalid, src_readdata,
    input  snk_read, snk_write, snk_address, snk_burstcount,
           snk_writedata, snk_byteenable,
    output snk_waitrequest, snk_readdatavalid, snk_readdata
  );
endinterface

// File: rtl/local_mem_avalon_arbiter_rd_tracker.sv
// In-order tracker of outstanding read commands.
//   push_i/push_entry_i : record an accepted read {src_id, burstcount}
//   rsp_vld_i           : one response beat from memory
//   full_o/empty_o      : occupancy (full_o is the pre-pop value)
//   pop_o               : head entry retires on this beat (its last one)
//   head_src_id_o       : source owning the current response beat
// A push while full is taken only when the same cycle pops; the slot being
// written is then the head being retired, whose fields were already used.
module local_mem_arb_rd_tracker
  import local_mem_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  t_rd_track_entry     push_entry_i,
  input  logic                rsp_vld_i,
  output logic                full_o,
  output logic                empty_o,
  output logic                pop_o,
  output logic [SRC_ID_W-1:0] head_src_id_o
);
  localparam int AW = $clog2(DEPTH);

  t_rd_track_entry       mem_q [DEPTH];
  t_rd_track_entry       head;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [TRK_BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic                  push_ok;

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign head_src_id_o = head.src_id;
  assign empty_o       = (wr_ptr_q == rd_ptr_q);
  assign full_o        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_o         = rsp_vld_i && !empty_o &&
                         ((beat_cnt_q + TRK_BCNT_W'(1)) == head.burstcount);
  assign push_ok       = push_i && (!full_o || pop_o);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_o) begin
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      beat_cnt_d = '0;
    end else if (rsp_vld_i && !empty_o) begin
      beat_cnt_d = beat_cnt_q + TRK_BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
  end

endmodule

// File: rtl/local_mem_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM local-memory bank among NUM_SRC
// engines. Write bursts keep the grant until their last beat; read
// responses are steered back to the issuer through an in-order tracker.
//   clk, reset         : clock, asynchronous active-high reset
//   bus (slave)        : per-source masters and the memory sink
//   err_unexpected_rsp : sticky, response beat arrived with no read pending
//   err_zero_burst     : sticky, a command was accepted with burstcount 0
module local_mem_avalon_arbiter
  import local_mem_arb_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RD_TRACK_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  local_mem_avalon_arbiter_if.slave  bus,
  output logic                       err_unexpected_rsp,
  output logic                       err_zero_burst
);
  t_arb_state                 state_q, state_d;
  logic [SRC_ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SRC_ID_W-1:0]        owner_q, owner_d;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [ADDR_WIDTH-1:0]      addr_hold_q;
  logic [BURST_CNT_WIDTH-1:0] bcnt_hold_q;
  logic                       err_unexp_q, err_zero_q;

  logic [MAX_SRC-1:0]         elig;
  t_rr_pick                   pick;
  logic                       gnt_vld;
  logic [SRC_ID_W-1:0]        gnt_idx;
  logic                       sel_read, sel_write;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [BURST_CNT_WIDTH-1:0] sel_bcnt, eff_bcnt;
  logic [DATA_WIDTH-1:0]      sel_wdata;
  logic [DATA_WIDTH/8-1:0]    sel_be;
  logic                       snk_read, snk_write, accept, zero_burst;
  logic [ADDR_WIDTH-1:0]      snk_addr;
  logic [BURST_CNT_WIDTH-1:0] snk_bcnt;

  logic                       trk_push, trk_full, trk_empty, trk_pop, trk_can_push;
  logic [SRC_ID_W-1:0]        trk_head_id;
  t_rd_track_entry            trk_entry;

  // A slot freed by this cycle's final response beat can take a new read.
  assign trk_can_push = !trk_full || trk_pop;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = bus.src_write[i] || (bus.src_read[i] && trk_can_push);
    end
  end

  assign pick    = rr_pick(elig, rr_ptr_q, NUM_SRC);
  assign gnt_idx = (state_q == WR_BURST) ? owner_q : pick.idx;
  assign gnt_vld = !reset && ((state_q == WR_BURST) || pick.vld);

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_bcnt  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx == SRC_ID_W'(i)) begin
        sel_read  = bus.src_read[i];
        sel_write = bus.src_write[i];
        sel_addr  = bus.src_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_bcnt  = bus.src_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        sel_wdata = bus.src_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_be    = bus.src_byteenable[i*(DATA_WIDTH/8) +: DATA_WIDTH/8];
      end
    end
  end

  assign eff_bcnt = (sel_bcnt == '0) ? BURST_CNT_WIDTH'(1) : sel_bcnt;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    beats_left_d = beats_left_q;
    snk_read     = 1'b0;
    snk_write    = 1'b0;
    snk_addr     = sel_addr;
    snk_bcnt     = sel_bcnt;
    trk_push     = 1'b0;
    zero_burst   = 1'b0;
    accept       = 1'b0;
    if (gnt_vld) begin
      if (state_q == ARB) begin
        // Write wins when a source illegally asserts both.
        snk_write = sel_write;
        snk_read  = sel_read && !sel_write;
      end else begin
        snk_write = sel_write;
        snk_addr  = addr_hold_q;
        snk_bcnt  = bcnt_hold_q;
      end
    end
    accept = (snk_read || snk_write) && !bus.snk_waitrequest;
    if (accept) begin
      if (state_q == ARB) begin
        rr_ptr_d   = (int'(pick.idx) == NUM_SRC - 1) ? '0 : pick.idx + SRC_ID_W'(1);
        zero_burst = (sel_bcnt == '0);
        if (snk_read) begin
          trk_push = 1'b1;
        end else if (eff_bcnt > BURST_CNT_WIDTH'(1)) begin
          state_d      = WR_BURST;
          owner_d      = pick.idx;
          beats_left_d = eff_bcnt - BURST_CNT_WIDTH'(1);
        end
      end else begin
        beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
        if (beats_left_q == BURST_CNT_WIDTH'(1)) state_d = ARB;
      end
    end
  end

  always_comb begin
    bus.src_waitrequest   = '1;
    bus.src_readdatavalid = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_waitrequest[i]   = !(gnt_vld && (gnt_idx == SRC_ID_W'(i)) && !bus.snk_waitrequest);
      bus.src_readdatavalid[i] = bus.snk_readdatavalid && !trk_empty &&
                                 (trk_head_id == SRC_ID_W'(i));
    end
  end

  assign bus.src_readdata   = bus.snk_readdata;
  assign bus.snk_read       = snk_read;
  assign bus.snk_write      = snk_write;
  assign bus.snk_address    = snk_addr;
  assign bus.snk_burstcount = snk_bcnt;
  assign bus.snk_writedata  = sel_wdata;
  assign bus.snk_byteenable = sel_be;

  assign trk_entry.src_id     = gnt_idx;
  assign trk_entry.burstcount = TRK_BCNT_W'(eff_bcnt);

  local_mem_arb_rd_tracker #(
    .DEPTH (RD_TRACK_DEPTH)
  ) u_rd_tracker (
    .clk           (clk),
    .reset         (reset),
    .push_i        (trk_push),
    .push_entry_i  (trk_entry),
    .rsp_vld_i     (bus.snk_readdatavalid),
    .full_o        (trk_full),
    .empty_o       (trk_empty),
    .pop_o         (trk_pop),
    .head_src_id_o (trk_head_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beats_left_q <= '0;
      err_unexp_q  <= 1'b0;
      err_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      beats_left_q <= beats_left_d;
      err_unexp_q  <= err_unexp_q || (bus.snk_readdatavalid && trk_empty);
      err_zero_q   <= err_zero_q || zero_burst;
    end
  end

  // First-beat address/burstcount are replayed for the rest of the burst.
  always_ff @(posedge clk) begin
    if (accept && (state_q == ARB)) begin
      addr_hold_q <= sel_addr;
      bcnt_hold_q <= sel_bcnt;
    end
  end

  assign err_unexpected_rsp = err_unexp_q;
  assign err_zero_burst     = err_zero_q;

endmodule
